// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game round controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPIN     = 3'd1,
        WAIT_KEY = 3'd2,
        JUDGE    = 3'd3,
        DONE     = 3'd4
    } game_state_e;

    localparam logic [3:0] MAX_SCORE = 4'd9;

    // Increment that sticks at the given ceiling instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] ceiling);
        logic [3:0] result;
        if (value >= ceiling) begin
            result = ceiling;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/answer_timer.sv
// Answer-window down-counter: loaded at window open, decremented per game tick.
module answer_timer #(
    parameter int unsigned ANSWER_TICKS = 8
) (
    input  logic clk_in,
    input  logic restart,
    input  logic load,
    input  logic dec,
    output logic expire
);

    localparam logic [3:0] LOAD_VAL = 4'(ANSWER_TICKS);

    logic [3:0] count_r;

    // Count register: load has priority over decrement, zero never wraps.
    always_ff @(posedge clk_in) begin
        if (restart) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // The tick that lands while one count remains closes the window.
    assign expire = (count_r == 4'd1);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: spin the motor, open a timed answer window, score, repeat.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ANSWER_TICKS = 8,
    parameter int unsigned NUM_ROUNDS   = 9
) (
    input  logic       clk_in,
    input  logic       restart,
    input  logic       tick,
    input  logic [1:0] rnd_dir,
    input  logic [1:0] rnd_dur,
    input  logic       motor_done,
    input  logic       key_valid,
    input  logic       answer,
    output logic       motor_start,
    output logic [1:0] motor_dir,
    output logic [1:0] motor_dur,
    output logic       answer_open,
    output logic [3:0] score,
    output logic [3:0] round_cnt,
    output logic       game_over
);

    localparam logic [3:0] ROUND_LIMIT = 4'(NUM_ROUNDS);

    game_state_e state_r;
    logic        key_prev_r;
    logic        hit_r;
    logic        motor_start_r;
    logic [1:0]  motor_dir_r;
    logic [1:0]  motor_dur_r;
    logic        answer_open_r;
    logic [3:0]  score_r;
    logic [3:0]  round_cnt_r;
    logic        game_over_r;

    logic        key_edge_s;
    logic        timer_load_s;
    logic        timer_dec_s;
    logic        timer_expire_s;
    logic [3:0]  round_next_s;

    // A held key only ever produces one edge, so a press carried into the window is ignored.
    assign key_edge_s   = key_valid & ~key_prev_r;
    assign timer_load_s = (state_r == SPIN) && motor_done;
    assign timer_dec_s  = (state_r == WAIT_KEY) && tick && !key_edge_s;
    assign round_next_s = round_cnt_r + 4'd1;

    answer_timer #(
        .ANSWER_TICKS(ANSWER_TICKS)
    ) u_answer_timer (
        .clk_in  (clk_in),
        .restart (restart),
        .load    (timer_load_s),
        .dec     (timer_dec_s),
        .expire  (timer_expire_s)
    );

    // Main FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (restart) begin
            state_r       <= IDLE;
            key_prev_r    <= 1'b0;
            hit_r         <= 1'b0;
            motor_start_r <= 1'b0;
            motor_dir_r   <= 2'd0;
            motor_dur_r   <= 2'd0;
            answer_open_r <= 1'b0;
            score_r       <= 4'd0;
            round_cnt_r   <= 4'd0;
            game_over_r   <= 1'b0;
        end else begin
            key_prev_r    <= key_valid;
            motor_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick) begin
                        motor_dir_r   <= rnd_dir;
                        motor_dur_r   <= rnd_dur;
                        motor_start_r <= 1'b1;
                        state_r       <= SPIN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SPIN: begin
                    // No timeout here: the motor driver is trusted to finish.
                    if (motor_done) begin
                        answer_open_r <= 1'b1;
                        state_r       <= WAIT_KEY;
                    end else begin
                        state_r <= SPIN;
                    end
                end
                WAIT_KEY: begin
                    // Key edge is checked first so it wins against the final tick.
                    if (key_edge_s) begin
                        hit_r         <= answer;
                        answer_open_r <= 1'b0;
                        state_r       <= JUDGE;
                    end else if (tick && timer_expire_s) begin
                        hit_r         <= 1'b0;
                        answer_open_r <= 1'b0;
                        state_r       <= JUDGE;
                    end else begin
                        state_r <= WAIT_KEY;
                    end
                end
                JUDGE: begin
                    if (hit_r) begin
                        score_r <= sat_inc(score_r, MAX_SCORE);
                    end else begin
                        score_r <= score_r;
                    end
                    round_cnt_r <= round_next_s;
                    if (round_next_s == ROUND_LIMIT) begin
                        game_over_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r       <= IDLE;
                    answer_open_r <= 1'b0;
                end
            endcase
        end
    end

    assign motor_start = motor_start_r;
    assign motor_dir   = motor_dir_r;
    assign motor_dur   = motor_dur_r;
    assign answer_open = answer_open_r;
    assign score       = score_r;
    assign round_cnt   = round_cnt_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: round table plus scoreboard monitor.
module tb_game_round_ctrl;

    localparam int T_ANS = 8;
    localparam int M_KEY = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_HELD = 2;
    localparam int M_FINAL = 3;

    typedef struct packed { logic [1:0] dir; logic [1:0] dur; } spin_exp_t;
    typedef struct packed { logic [3:0] score; logic [3:0] rnd; logic over; } judge_exp_t;
    typedef struct {
        logic [1:0] dir;
        logic [1:0] dur;
        int         mode;
        logic       ans;
        logic [3:0] exp_score;
        logic [3:0] exp_round;
        logic       exp_over;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       restart = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] rnd_dir = 2'd0;
    logic [1:0] rnd_dur = 2'd0;
    logic       motor_done = 1'b0;
    logic       key_valid = 1'b0;
    logic       answer = 1'b0;
    logic       motor_start;
    logic [1:0] motor_dir;
    logic [1:0] motor_dur;
    logic       answer_open;
    logic [3:0] score;
    logic [3:0] round_cnt;
    logic       game_over;

    int n_checks = 0;
    int n_fail = 0;

    spin_exp_t  spin_q[$];
    judge_exp_t judge_q[$];
    vec_t       vecs[9];

    logic       mon_rst;
    logic       prev_start = 1'b0;
    logic [3:0] prev_round = 4'd0;
    spin_exp_t  se;
    judge_exp_t je_mon;

    game_round_ctrl #(.ANSWER_TICKS(T_ANS), .NUM_ROUNDS(9)) dut (
        .clk_in      (clk_in),
        .restart     (restart),
        .tick        (tick),
        .rnd_dir     (rnd_dir),
        .rnd_dur     (rnd_dur),
        .motor_done  (motor_done),
        .key_valid   (key_valid),
        .answer      (answer),
        .motor_start (motor_start),
        .motor_dir   (motor_dir),
        .motor_dur   (motor_dur),
        .answer_open (answer_open),
        .score       (score),
        .round_cnt   (round_cnt),
        .game_over   (game_over)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_motor_start"}, int'(motor_start), 0);
        check({tag, "_motor_dir"}, int'(motor_dir), 0);
        check({tag, "_motor_dur"}, int'(motor_dur), 0);
        check({tag, "_answer_open"}, int'(answer_open), 0);
        check({tag, "_score"}, int'(score), 0);
        check({tag, "_round_cnt"}, int'(round_cnt), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        spin_q.delete();
        judge_q.delete();
    endtask

    // Scoreboard monitor: pops expectations when the DUT issues a spin or finishes a judgement.
    always @(posedge clk_in) begin
        mon_rst = restart;
        #1;
        if (mon_rst) begin
            prev_round = round_cnt;
            prev_start = 1'b0;
        end else begin
            if (motor_start) begin
                check("motor_start_single_cycle", int'(prev_start), 0);
                if (spin_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_motor_start: got 1, expected 0");
                end else begin
                    se = spin_q.pop_front();
                    check("sb_motor_dir", int'(motor_dir), int'(se.dir));
                    check("sb_motor_dur", int'(motor_dur), int'(se.dur));
                end
            end
            prev_start = motor_start;
            if (round_cnt != prev_round) begin
                if (judge_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_judge: round_cnt %0d, expected %0d", round_cnt, prev_round);
                end else begin
                    je_mon = judge_q.pop_front();
                    check("sb_score", int'(score), int'(je_mon.score));
                    check("sb_round_cnt", int'(round_cnt), int'(je_mon.rnd));
                    check("sb_game_over", int'(game_over), int'(je_mon.over));
                end
                prev_round = round_cnt;
            end
        end
    end

    task automatic play(input vec_t v);
        judge_exp_t je;
        je = '{score: v.exp_score, rnd: v.exp_round, over: v.exp_over};
        spin_q.push_back('{dir: v.dir, dur: v.dur});
        rnd_dir = v.dir;
        rnd_dur = v.dur;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("motor_start_on", int'(motor_start), 1);
        check("motor_dir_latch", int'(motor_dir), int'(v.dir));
        check("motor_dur_latch", int'(motor_dur), int'(v.dur));
        rnd_dir = ~v.dir;
        rnd_dur = ~v.dur;
        step();
        check("motor_start_off", int'(motor_start), 0);
        check("motor_dir_hold", int'(motor_dir), int'(v.dir));
        if (v.mode == M_HELD) begin
            key_valid = 1'b1;
            answer = v.ans;
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("spin_no_open", int'(answer_open), 0);
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        check("answer_open_on", int'(answer_open), 1);
        case (v.mode)
            M_KEY: begin
                step();
                judge_q.push_back(je);
                key_valid = 1'b1;
                answer = v.ans;
                step();
                answer = ~v.ans;
                check("key_closes_window", int'(answer_open), 0);
            end
            M_TIMEOUT: begin
                for (int i = 1; i <= T_ANS; i++) begin
                    if (i == T_ANS) judge_q.push_back(je);
                    tick = 1'b1;
                    step();
                    tick = 1'b0;
                    check($sformatf("timeout_open_after_tick%0d", i), int'(answer_open), (i < T_ANS) ? 1 : 0);
                    if (i < T_ANS) step();
                end
            end
            M_HELD: begin
                step();
                step();
                check("held_key_no_judge", int'(answer_open), 1);
                key_valid = 1'b0;
                step();
                judge_q.push_back(je);
                key_valid = 1'b1;
                step();
                answer = ~v.ans;
            end
            default: begin
                for (int i = 1; i < T_ANS; i++) begin
                    tick = 1'b1;
                    step();
                    tick = 1'b0;
                    step();
                end
                judge_q.push_back(je);
                tick = 1'b1;
                key_valid = 1'b1;
                answer = v.ans;
                step();
                tick = 1'b0;
                answer = ~v.ans;
            end
        endcase
        for (int i = 0; i < 16 && judge_q.size() != 0; i++) step();
        check("judge_within_budget", int'(judge_q.size()), 0);
        check("round_score", int'(score), int'(v.exp_score));
        check("round_round_cnt", int'(round_cnt), int'(v.exp_round));
        check("round_game_over", int'(game_over), int'(v.exp_over));
        key_valid = 1'b0;
        answer = 1'b0;
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{2'd2, 2'd3, M_KEY,     1'b1, 4'd1, 4'd1, 1'b0};
        vecs[1] = '{2'd1, 2'd0, M_TIMEOUT, 1'b1, 4'd1, 4'd2, 1'b0};
        vecs[2] = '{2'd3, 2'd1, M_HELD,    1'b1, 4'd2, 4'd3, 1'b0};
        vecs[3] = '{2'd0, 2'd2, M_FINAL,   1'b1, 4'd3, 4'd4, 1'b0};
        vecs[4] = '{2'd2, 2'd2, M_KEY,     1'b0, 4'd3, 4'd5, 1'b0};
        vecs[5] = '{2'd1, 2'd3, M_FINAL,   1'b0, 4'd3, 4'd6, 1'b0};
        vecs[6] = '{2'd3, 2'd3, M_KEY,     1'b1, 4'd4, 4'd7, 1'b0};
        vecs[7] = '{2'd0, 2'd1, M_HELD,    1'b0, 4'd4, 4'd8, 1'b0};
        vecs[8] = '{2'd2, 2'd0, M_KEY,     1'b1, 4'd5, 4'd9, 1'b1};

        step();
        do_restart();
        check_reset("reset");

        for (int r = 0; r < 9; r++) play(vecs[r]);

        // After game over every stimulus except restart must be ignored.
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            motor_done = 1'b1;
            key_valid = 1'b1;
            answer = 1'b1;
            step();
            tick = 1'b0;
            key_valid = 1'b0;
            step();
        end
        motor_done = 1'b0;
        answer = 1'b0;
        check("done_score_hold", int'(score), 5);
        check("done_round_hold", int'(round_cnt), 9);
        check("done_game_over", int'(game_over), 1);
        check("done_window_closed", int'(answer_open), 0);

        do_restart();
        check_reset("restart_done");

        for (int r = 0; r < 9; r++) begin
            v = '{2'(r), 2'(r + 1), M_KEY, 1'b1, 4'(r + 1), 4'(r + 1), (r == 8)};
            play(v);
        end
        check("all_hit_score", int'(score), 9);
        check("all_hit_game_over", int'(game_over), 1);

        do_restart();
        spin_q.push_back('{dir: 2'd3, dur: 2'd2});
        rnd_dir = 2'd3;
        rnd_dur = 2'd2;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_reset("restart_spin");
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        check("idle_ignores_motor_done", int'(answer_open), 0);
        for (int i = 0; i < 4; i++) step();
        check("no_restart_reissue", int'(motor_start), 0);

        check("spin_q_drained", int'(spin_q.size()), 0);
        check("judge_q_drained", int'(judge_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
